// File: rtl/shiftreg_in.sv
// Serial-to-parallel receiver: synchronizes an external serial clock/data pair into set_clk,
// assembles MSB-first frames and presents them in a double-buffered holding register.
module shiftreg_in #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter bit          SAMPLE_RISING = 1'b1
) (
   input  logic             set_clk,
   input  logic             reset,
   input  logic             serial_clk,
   input  logic             serial_in,
   input  logic             frame_en,
   input  logic             read_enable,
   output logic [WIDTH-1:0] data_out,
   output logic             data_ready,
   output logic             overrun,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StShift, StTransfer} state_e;

   localparam logic [3:0] LastCnt = 4'(WIDTH - 1);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [3:0]             count_q, count_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   ready_q, ready_d;
   logic                   ovr_q, ovr_d;
   logic [SYNC_STAGES-1:0] clk_sync_q, din_sync_q, fen_sync_q;
   logic                   clk_prev_q;
   logic                   rd_hi_q;

   logic clk_s, din_s, fen_s, sample_edge, rd_accept;

   // Equal-depth chains keep sampled data aligned with its clock.
   always_ff @(posedge set_clk or posedge reset) begin
      if (reset) begin
         clk_sync_q <= '0;
         din_sync_q <= '0;
         fen_sync_q <= '0;
         clk_prev_q <= 1'b0;
         rd_hi_q    <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], serial_clk};
         din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], serial_in};
         fen_sync_q <= {fen_sync_q[SYNC_STAGES-2:0], frame_en};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         rd_hi_q    <= read_enable;
      end
   end

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign din_s = din_sync_q[SYNC_STAGES-1];
   assign fen_s = fen_sync_q[SYNC_STAGES-1];

   assign sample_edge = SAMPLE_RISING ? (clk_s & ~clk_prev_q) : (~clk_s & clk_prev_q);
   // A held-low strobe is accepted only on its first low cycle.
   assign rd_accept   = rd_hi_q & ~read_enable;

   always_ff @(posedge set_clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         count_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      data_d  = data_q;
      ready_d = ready_q;
      ovr_d   = ovr_q;

      if (rd_accept) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            count_d = '0;
            if (fen_s) state_d = StShift;
         end
         StShift: begin
            if (!fen_s) begin
               state_d = StIdle;
               count_d = '0;
               shift_d = '0;
            end else if (sample_edge) begin
               shift_d = {shift_q[WIDTH-2:0], din_s};
               count_d = count_q + 4'd1;
               if (count_q == LastCnt) state_d = StTransfer;
            end
         end
         StTransfer: begin
            // Transfer overrides a same-cycle read: the old byte counts as consumed.
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !rd_accept) ovr_d = 1'b1;
            count_d = '0;
            state_d = fen_s ? StShift : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_out   = data_q;
   assign data_ready = ready_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_shiftreg_in.sv
// Directed bench for shiftreg_in: serial_clk = set_clk/8, MSB-first frames, hand-computed results.
module tb_shiftreg_in;

   logic       set_clk = 1'b0;
   logic       reset = 1'b1;
   logic       serial_clk = 1'b0;
   logic       serial_in = 1'b0;
   logic       frame_en = 1'b0;
   logic       read_enable = 1'b1;
   logic [7:0] data_out;
   logic       data_ready;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad = 0;

   shiftreg_in #(
      .WIDTH        (8),
      .SYNC_STAGES  (2),
      .SAMPLE_RISING(1'b1)
   ) dut (
      .set_clk    (set_clk),
      .reset      (reset),
      .serial_clk (serial_clk),
      .serial_in  (serial_in),
      .frame_en   (frame_en),
      .read_enable(read_enable),
      .data_out   (data_out),
      .data_ready (data_ready),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 set_clk = ~set_clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge set_clk);
   endtask

   // Data changes with the low phase, sampled on the serial_clk rising edge.
   task automatic send_bit(input logic b);
      serial_in  = b;
      serial_clk = 1'b0;
      cycles(4);
      serial_clk = 1'b1;
      cycles(4);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic do_read();
      read_enable = 1'b0;
      cycles(1);
      read_enable = 1'b1;
      cycles(1);
   endtask

   initial begin
      cycles(2);
      check("reset_data", 16'(data_out), 16'h00);
      check("reset_flags", {13'd0, data_ready, overrun, busy}, 16'h0);
      reset = 1'b0;
      cycles(2);

      // Single frame, latency bounded to SYNC_STAGES+3 after the last edge.
      frame_en = 1'b1;
      cycles(4);
      check("busy_after_fen", 16'(busy), 16'h1);
      send_byte(8'hA5);
      if (!data_ready) cycles(1);
      check("a5_ready", 16'(data_ready), 16'h1);
      check("a5_data", 16'(data_out), 16'hA5);
      check("a5_busy", 16'(busy), 16'h1);
      do_read();
      check("a5_read_clears", {14'd0, data_ready, overrun}, 16'h0);

      // Back-to-back with reads between.
      send_byte(8'h3C);
      cycles(2);
      check("3c_data", 16'(data_out), 16'h3C);
      check("3c_flags", {14'd0, data_ready, overrun}, 16'h2);
      do_read();
      check("3c_read", 16'(data_ready), 16'h0);
      send_byte(8'hC3);
      cycles(2);
      check("c3_data", 16'(data_out), 16'hC3);
      check("c3_flags", {14'd0, data_ready, overrun}, 16'h2);
      do_read();

      // Overrun: newest byte wins, single read clears both flags.
      send_byte(8'h01);
      send_byte(8'h80);
      cycles(2);
      check("ovr_data", 16'(data_out), 16'h80);
      check("ovr_flags", {14'd0, data_ready, overrun}, 16'h3);
      do_read();
      check("ovr_read", {14'd0, data_ready, overrun}, 16'h0);

      // Abort after 5 bits, then a clean frame.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      frame_en = 1'b0;
      cycles(6);
      check("abort_busy", 16'(busy), 16'h0);
      check("abort_ready", 16'(data_ready), 16'h0);
      check("abort_data_kept", 16'(data_out), 16'h80);
      frame_en = 1'b1;
      cycles(4);
      send_byte(8'h12);
      cycles(2);
      check("12_data", 16'(data_out), 16'h12);
      check("12_flags", {14'd0, data_ready, overrun}, 16'h2);
      do_read();

      // Read strobe lands on the TRANSFER cycle of the second byte.
      send_byte(8'h77);
      for (int i = 7; i >= 1; i--) send_bit(1'(8'h9E >> i));
      serial_in  = 1'b0;
      serial_clk = 1'b0;
      cycles(4);
      serial_clk = 1'b1;
      cycles(3);
      read_enable = 1'b0;
      cycles(1);
      read_enable = 1'b1;
      check("xfer_read_data", 16'(data_out), 16'h9E);
      check("xfer_read_flags", {14'd0, data_ready, overrun}, 16'h2);
      cycles(4);

      // Long low strobe counts once; a byte arriving meanwhile stays unread.
      read_enable = 1'b0;
      cycles(20);
      check("hold_clear", 16'(data_ready), 16'h0);
      send_byte(8'h44);
      cycles(2);
      check("hold_no_reclear", 16'(data_ready), 16'h1);
      check("hold_data", 16'(data_out), 16'h44);
      read_enable = 1'b1;
      cycles(1);

      // Mid-frame reset, then a full frame.
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      reset = 1'b1;
      #1;
      check("rst_data", 16'(data_out), 16'h00);
      check("rst_flags", {13'd0, data_ready, overrun, busy}, 16'h0);
      serial_clk = 1'b0;
      frame_en   = 1'b0;
      cycles(2);
      reset = 1'b0;
      cycles(2);
      frame_en = 1'b1;
      cycles(4);
      send_byte(8'h5A);
      cycles(2);
      check("5a_data", 16'(data_out), 16'h5A);
      check("5a_flags", {14'd0, data_ready, overrun}, 16'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shiftreg_in.md
Name: shiftreg_in

Overview:
- Serial-to-parallel receiver, the counterpart of the byte-wide serial transmitter on the MSX-side SPI path.
- Samples an external serial clock/data pair inside the set_clk domain and assembles MSB-first bytes.
- Presents each completed byte in a holding register for the host bus, with a ready flag, an overrun flag and an active-low read strobe.
- Holding register is double-buffered: the next byte can shift in while the host reads the previous one.

Parameters:
- WIDTH, 8, bits per frame (2..15).
- SYNC_STAGES, 2, synchronizer depth for serial_clk, serial_in and frame_en (>=2).
- SAMPLE_RISING, 1, 1 = sample on serial_clk rising edge, 0 = falling edge.

Ports:
- set_clk  input  1  system/bus clock; all state is in this domain.
- reset  input  1  asynchronous, active-high.
- serial_clk  input  1  external shift clock, asynchronous to set_clk.
- serial_in  input  1  serial data, MSB first.
- frame_en  input  1  high = frame in progress; low aborts and clears the partial byte.
- read_enable  input  1  active-low host read strobe, level-sampled on set_clk.
- data_out  output  WIDTH  holding register; stable between transfers.
- data_ready  output  1  holding register contains an unread byte.
- overrun  output  1  an unread byte was overwritten.
- busy  output  1  receiver is not IDLE.

Behaviour:
- Reset (async, active-high): state IDLE, shift register 0, bit count 0, data_out 0, data_ready 0, overrun 0, busy 0, synchronizer and edge history 0.
- Sync: serial_clk, serial_in and frame_en each pass through SYNC_STAGES flops with identical delay, so sampled data stays aligned with its clock.
- Sample edge: detected when the last sync stage differs from a one-cycle-delayed copy in the SAMPLE_RISING direction. This is a one-cycle pulse.
- Serial timing requirement: serial_clk high and low phases each >= 2 set_clk periods. Faster clocks are unsupported and edges may be lost.
- State IDLE:
  - Bit count held at 0.
  - Synchronized frame_en high -> SHIFT on the next edge.
  - Sample edges are ignored.
- State SHIFT, on each sample edge:
  - shift <= {shift[WIDTH-2:0], serial_in_sync}; count <= count + 1.
  - On the edge that makes count == WIDTH -> TRANSFER.
- SHIFT abort: synchronized frame_en low -> IDLE. Partial byte discarded, count 0, data_ready and data_out untouched.
  - If frame_en drops and a sample edge occur in the same cycle, the abort wins.
- State TRANSFER (exactly 1 cycle):
  - data_out <= shift; data_ready <= 1.
  - If data_ready was already 1 and no read strobe is accepted this cycle, overrun <= 1 (newest byte wins).
  - Count <= 0. Next state is SHIFT if frame_en is synchronized high, otherwise IDLE.
  - A frame_en drop during TRANSFER does not cancel the transfer.
- Latency: data_ready rises 1 set_clk cycle after the shift of the final bit. That is SYNC_STAGES+2 to SYNC_STAGES+3 cycles after the last serial_clk sampling edge at the pins.
- Read handshake:
  - A read strobe is accepted in the first set_clk cycle read_enable is sampled low after being high; a held-low level counts once.
  - On acceptance: data_ready <= 0 and overrun <= 0.
  - data_out is readable at any time and is not altered by reads.
- Read and TRANSFER in the same cycle: the transfer wins. data_ready stays 1, overrun is not set (the old byte counts as consumed), and the new byte is in data_out.
- busy = (state != IDLE). It is combinational from the state register.
- Count width is 4 bits and never wraps past WIDTH; the count is reset in TRANSFER and IDLE.

Test Plan:
- Reset then frame_en=1; send 0xA5 MSB-first at serial_clk = set_clk/8 -> data_out=0xA5, data_ready=1 within SYNC_STAGES+3 cycles of the 8th edge; busy=1 until frame_en low.
- Back-to-back 0x3C, 0xC3 with frame_en held high and a read strobe between them -> each byte appears in turn; overrun stays 0; data_ready pulses low for the read then rises again.
- Two bytes 0x01, 0x80 with no read -> data_out=0x80, data_ready=1, overrun=1. A single read-strobe cycle clears both flags.
- frame_en dropped after 5 bits of 0xFF, then a full frame of 0x12 -> data_out=0x12 (no corrupted byte), data_ready asserts only once.
- Read strobe aligned to the TRANSFER cycle of a second byte -> data_ready=1, overrun=0, data_out=new byte. A read strobe held low for 20 cycles clears only once.
- Assert reset mid-frame after 3 bits -> all outputs 0 immediately; the next full frame of 0x5A receives correctly.
